// File: rtl/sdram_pkg.sv
// Shared SDRAM client definitions: address field widths, data width,
// command-port arbiter state encoding and a small index-width helper.
package sdram_pkg;

  localparam int unsigned BankWidth = 2;
  localparam int unsigned RowWidth  = 12;
  localparam int unsigned ColWidth  = 9;
  localparam int unsigned AddrWidth = BankWidth + RowWidth + ColWidth;
  localparam int unsigned DataWidth = 16;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_SETTLE,
    ARB_WAIT_READ,
    ARB_WAIT_READY
  } arb_state_e;

  // Bits needed to hold an index in 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
// Ports:
//   req        in  N     request vector
//   last_grant in  IdxW  index granted most recently
//   grant      out N     one-hot winner (zero when no request)
//   grant_idx  out IdxW  binary index of the winner
//   valid      out 1     at least one request present
module rr_picker
  import sdram_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last_grant,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx,
  output logic            valid
);

  logic [IdxW-1:0] cand;

  // Search starts one past the last winner and wraps modulo N.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdxW'((32'(last_grant) + k) % N);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller command port between N
// requesters; forwards one command at a time and routes read data back to
// the requester that issued the read.
// Ports:
//   clk, rst_                     clock, async active-low reset
//   req_trigger/ready/addr/write/writeData   per-requester command handshake
//   req_readData, req_readDataValid         registered read return
//   ctrl_cmd*                     controller command port
//   err                           sticky: read data arrived unexpectedly
module sdram_arbiter #(
  parameter int unsigned N         = 2,
  parameter int unsigned AddrWidth = sdram_pkg::AddrWidth,
  parameter int unsigned DataWidth = sdram_pkg::DataWidth
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [N-1:0]           req_trigger,
  output logic [N-1:0]           req_ready,
  input  logic [N*AddrWidth-1:0] req_addr,
  input  logic [N-1:0]           req_write,
  input  logic [N*DataWidth-1:0] req_writeData,
  output logic [DataWidth-1:0]   req_readData,
  output logic [N-1:0]           req_readDataValid,
  input  logic                   ctrl_cmdReady,
  output logic                   ctrl_cmdTrigger,
  output logic [AddrWidth-1:0]   ctrl_cmdAddr,
  output logic                   ctrl_cmdWrite,
  output logic [DataWidth-1:0]   ctrl_cmdWriteData,
  input  logic [DataWidth-1:0]   ctrl_cmdReadData,
  input  logic                   ctrl_cmdReadDataValid,
  output logic                   err
);
  import sdram_pkg::*;

  localparam int unsigned IdxW = idx_width(N);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      last_grant_q, owner_q, pick_idx;
  logic [N-1:0]         pick_grant;
  logic                 pick_valid;
  logic [AddrWidth-1:0] hold_addr_q;
  logic                 hold_write_q;
  logic [DataWidth-1:0] hold_data_q;
  logic                 accept, rd_accept;

  rr_picker #(.N(N)) u_picker (
    .req        (req_trigger),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .valid      (pick_valid)
  );

  // Accept is combinational in Idle; gated by reset so ready stays low in reset.
  assign accept          = (state_q == ARB_IDLE) && pick_valid && rst_;
  assign req_ready       = accept ? pick_grant : '0;
  assign ctrl_cmdTrigger = (state_q == ARB_ISSUE) && ctrl_cmdReady;
  assign ctrl_cmdAddr      = hold_addr_q;
  assign ctrl_cmdWrite     = hold_write_q;
  assign ctrl_cmdWriteData = hold_data_q;

  // Read data is expected only in WaitRead, or in Settle of a read command.
  assign rd_accept = ctrl_cmdReadDataValid &&
                     ((state_q == ARB_WAIT_READ) ||
                      ((state_q == ARB_SETTLE) && !hold_write_q));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:       if (pick_valid) state_d = ARB_ISSUE;
      ARB_ISSUE:      if (ctrl_cmdReady) state_d = ARB_SETTLE;
      ARB_SETTLE:     state_d = (hold_write_q || rd_accept) ? ARB_WAIT_READY : ARB_WAIT_READ;
      ARB_WAIT_READ:  if (rd_accept) state_d = ARB_WAIT_READY;
      ARB_WAIT_READY: if (ctrl_cmdReady) state_d = ARB_IDLE;
      default:        state_d = ARB_IDLE;
    endcase
  end

  // State, hold registers and registered read-return outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q           <= ARB_IDLE;
      last_grant_q      <= IdxW'(N - 1);
      owner_q           <= '0;
      hold_addr_q       <= '0;
      hold_write_q      <= 1'b0;
      hold_data_q       <= '0;
      req_readData      <= '0;
      req_readDataValid <= '0;
      err               <= 1'b0;
    end else begin
      state_q           <= state_d;
      req_readDataValid <= '0;
      if (accept) begin
        owner_q      <= pick_idx;
        last_grant_q <= pick_idx;
        hold_addr_q  <= req_addr[pick_idx * AddrWidth +: AddrWidth];
        hold_write_q <= req_write[pick_idx];
        hold_data_q  <= req_writeData[pick_idx * DataWidth +: DataWidth];
      end
      if (rd_accept) begin
        req_readData      <= ctrl_cmdReadData;
        req_readDataValid <= N'(1) << owner_q;
      end else if (ctrl_cmdReadDataValid) begin
        err <= 1'b1;
      end
    end
  end

endmodule
